// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display path: segment codes and digit index helpers.
package bcd_disp_pkg;

  localparam int IDX_W = 2;

  typedef logic [6:0]       seg_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_R     = 7'h50;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  // Highest digit index; the scan wraps back to 0 after it
  localparam idx_t IDX_LAST = 2'd2;

  // One-hot digit enable for a digit index (out-of-range folds onto the last digit)
  function automatic logic [2:0] idx_onehot(input idx_t idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      default: oh = 3'b100;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-high 7-segment code; non-BCD values show a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  // Plain lookup; codes 10..15 are not decimal digits and render as a dash
  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd3_seg_scan.sv
// Three-digit multiplexed 7-segment driver: captures a BCD result into shadow
// registers and scans it onto a shared segment bus with one-hot digit enables.
module bcd3_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       invalid_in,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Pin-level reset values with polarity already applied
  localparam seg_t       SEG_RST = ACTIVE_LOW ? ~SEG_0 : SEG_0;
  localparam logic [2:0] AN_RST  = ACTIVE_LOW ? 3'b110 : 3'b001;

  logic [DIV_W-1:0] div_q, div_d;
  idx_t             idx_q, idx_d;
  logic             terminal;
  logic             wrap_q;

  logic [3:0]       sh_d0_q, sh_d1_q, sh_d2_q;
  logic             sh_inv_q;

  logic [3:0]       digit_mux;
  seg_t             digit_code;
  seg_t             code_d;
  logic             blank2, blank1;

  logic [6:0]       seg_q;
  logic [2:0]       an_q;
  logic             frame_q;

  // Prescaler and digit index next-state
  always_comb begin
    terminal = (div_q == DIV_LAST);
    div_d    = terminal ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (terminal) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + idx_t'(1);
    end
  end

  // Scan timing state; wrap_q delays the frame marker so it lines up with an showing digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      wrap_q <= terminal && (idx_q == IDX_LAST);
    end
  end

  // Shadow capture of the adder result
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_d0_q  <= '0;
      sh_d1_q  <= '0;
      sh_d2_q  <= '0;
      sh_inv_q <= 1'b0;
    end else if (load) begin
      sh_d0_q  <= d0;
      sh_d1_q  <= d1;
      sh_d2_q  <= d2;
      sh_inv_q <= invalid_in;
    end
  end

  // Select the shadow digit for the current scan position
  always_comb begin
    case (idx_q)
      2'd0:    digit_mux = sh_d0_q;
      2'd1:    digit_mux = sh_d1_q;
      default: digit_mux = sh_d2_q;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (digit_mux),
    .seg_o (digit_code)
  );

  // Error text beats blanking, blanking beats the decoded digit
  always_comb begin
    blank2 = blank_lz && (sh_d2_q == 4'd0);
    blank1 = blank2 && (sh_d1_q == 4'd0);
    code_d = digit_code;
    if (sh_inv_q) begin
      code_d = (idx_q == IDX_LAST) ? SEG_E : SEG_R;
    end else if (((idx_q == IDX_LAST) && blank2) || ((idx_q == 2'd1) && blank1)) begin
      code_d = SEG_BLANK;
    end
  end

  // Registered pin outputs with board polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= SEG_RST;
      an_q    <= AN_RST;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= ACTIVE_LOW ? ~code_d : code_d;
      an_q    <= ACTIVE_LOW ? ~idx_onehot(idx_q) : idx_onehot(idx_q);
      frame_q <= wrap_q;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd3_seg_scan.sv
// Scoreboard bench for bcd3_seg_scan: a cycle-level reference model pushes the
// expected pins for every clock edge; a monitor pops and compares both polarities.
module tb_bcd3_seg_scan;

  localparam int D = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;
  } exp_t;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0;
  logic       invalid_in = 1'b0;
  logic       blank_lz = 1'b0;

  logic [6:0] seg_h, seg_l;
  logic [2:0] an_h, an_l;
  logic       frame_h, frame_l;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  exp_t sb_q[$];

  // Reference model state: edges since reset, captured digits, invalid flag
  int n = 0;
  int m_d [3] = '{0, 0, 0};
  bit m_inv = 1'b0;
  bit cur_blz = 1'b0;

  always #5 clk = ~clk;

  bcd3_seg_scan #(.SCAN_DIV(D), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .d0(d0), .d1(d1), .d2(d2),
    .invalid_in(invalid_in), .blank_lz(blank_lz),
    .seg(seg_h), .an(an_h), .frame(frame_h)
  );

  bcd3_seg_scan #(.SCAN_DIV(D), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .load(load), .d0(d0), .d1(d1), .d2(d2),
    .invalid_in(invalid_in), .blank_lz(blank_lz),
    .seg(seg_l), .an(an_l), .frame(frame_l)
  );

  // What digit position pos should show, from the display rules
  function automatic logic [6:0] model_seg(input int pos, input bit blz);
    if (m_inv) return (pos == 2) ? 7'h79 : 7'h50;
    if (blz && pos == 2 && m_d[2] == 0) return 7'h00;
    if (blz && pos == 1 && m_d[2] == 0 && m_d[1] == 0) return 7'h00;
    return SEG_TAB[m_d[pos]];
  endfunction

  // Apply one cycle of stimulus and queue the pins expected after the coming edge
  task automatic drive(input bit r, input bit ld, input bit inv, input bit blz,
                       input int a2, input int a1, input int a0);
    exp_t e;
    int pos;
    @(negedge clk);
    rst = r; load = ld; invalid_in = inv; blank_lz = blz;
    d2 = a2[3:0]; d1 = a1[3:0]; d0 = a0[3:0];
    if (r) begin
      e.seg = 7'h3F; e.an = 3'b001; e.frame = 1'b0;
      n = 0; m_d = '{0, 0, 0}; m_inv = 1'b0;
    end else begin
      pos     = (n / D) % 3;
      e.seg   = model_seg(pos, blz);
      e.an    = 3'(1 << pos);
      e.frame = (n > 0) && (n % (3 * D) == 0);
      if (ld) begin
        m_d[0] = a0 & 15; m_d[1] = a1 & 15; m_d[2] = a2 & 15; m_inv = inv;
        $display("load d2=%0d d1=%0d d0=%0d inv=%0b blz=%0b at phase %0d", a2, a1, a0, inv, blz, n % (3 * D));
      end
      n++;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, cur_blz, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: every edge the DUT presents fresh pins; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("seg",      seg_h,             e.seg);
        chk("an",       {4'b0, an_h},      {4'b0, e.an});
        chk("frame",    {6'b0, frame_h},   {6'b0, e.frame});
        chk("seg_al",   seg_l,             ~e.seg);
        chk("an_al",    {4'b0, an_l},      {4'b0, ~e.an});
        chk("frame_al", {6'b0, frame_l},   {6'b0, e.frame});
      end
    end
  end

  initial begin
    int hold;
    int a2, a1, a0;
    bit ld, inv, r;

    // Reset and free-running scan
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(24);

    // Plain digits
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1, 5, 8);
    idle(12);

    // Leading-zero blanking
    cur_blz = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 7);
    idle(12);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 3, 7);
    idle(12);

    // Error display overrides digits and blanking, then recovery
    drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    idle(12);
    cur_blz = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 4, 2);
    idle(12);

    // Load coinciding with a terminal edge
    while (n % D != D - 1) idle(1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1, 9, 3);
    idle(12);

    // Reset while the hundreds digit is lit
    while (!(((n / D) % 3 == 2) && (n % D == 1))) idle(1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(20);

    // Randomized traffic: sparse loads, held-load bursts, odd digits, live blanking, rare resets
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) cur_blz = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 249) == 0);
      if (hold == 0 && $urandom_range(0, 59) == 0) hold = $urandom_range(2, 6);
      ld = (hold > 0) || ($urandom_range(0, 9) == 0);
      if (hold > 0) hold--;
      inv = ($urandom_range(0, 7) == 0);
      a2 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1);
      a1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      a0 = $urandom_range(0, 15);
      drive(r, ld, inv, cur_blz, a2, a1, a0);
    end
    idle(2);

    @(posedge clk);
    #2;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got=%0d want=0 pending", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
